// File: rtl/bram_bank_xbar.sv
// bram_bank_xbar
//   Banked RAM with one private write agent per bank and a read crossbar that
//   lets any read agent reach any bank. Each bank has a round-robin arbiter
//   across readers. Requests use a valid/ready handshake. The response arrives
//   one cycle after acceptance as a single-cycle rd_dvalid pulse.
//
// Ports
//   aclk, aresetn   clock (rising edge) and asynchronous active-low reset
//   wren/wraddr/wrdata        per-bank write port (bank i owned by write agent i)
//   rd_valid/rd_ready         per-reader request handshake
//   rd_bank/rd_addr           per-reader target bank and word address
//   rd_dvalid/rd_data/rd_err  per-reader response; rd_err flags a bank index
//                             that does not exist (rd_data reads 0 in that case)
//
// Configuration macro
//   MEDURAM_WR_BYPASS_EN  when defined, a same-cycle write to the address being
//                         read in the same bank is forwarded (write-first).
//                         When undefined, the bank behaves read-first and maps
//                         onto a plain block RAM.
module bram_bank_xbar #(
  parameter int NB_WRAGENT = 2,
  parameter int NB_RDAGENT = 2,
  parameter int ADDR_WIDTH = 3,
  parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
  parameter int DATA_WIDTH = 8,
  localparam int BANK_W    = (NB_WRAGENT > 1) ? $clog2(NB_WRAGENT) : 1
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NB_WRAGENT-1:0]            wren,
  input  logic [ADDR_WIDTH*NB_WRAGENT-1:0] wraddr,
  input  logic [DATA_WIDTH*NB_WRAGENT-1:0] wrdata,
  input  logic [NB_RDAGENT-1:0]            rd_valid,
  output logic [NB_RDAGENT-1:0]            rd_ready,
  input  logic [BANK_W*NB_RDAGENT-1:0]     rd_bank,
  input  logic [ADDR_WIDTH*NB_RDAGENT-1:0] rd_addr,
  output logic [NB_RDAGENT-1:0]            rd_dvalid,
  output logic [DATA_WIDTH*NB_RDAGENT-1:0] rd_data,
  output logic [NB_RDAGENT-1:0]            rd_err
);

  localparam int RD_W      = (NB_RDAGENT > 1) ? $clog2(NB_RDAGENT) : 1;
  localparam bit ADDR_FULL = (RAM_DEPTH == 2**ADDR_WIDTH);
  localparam bit BANK_FULL = ((2**BANK_W) == NB_WRAGENT);

  logic [BANK_W-1:0]     rbank    [NB_RDAGENT];
  logic [ADDR_WIDTH-1:0] raddr    [NB_RDAGENT];
  logic [NB_RDAGENT-1:0] oob;
  logic [NB_RDAGENT-1:0] gnt;
  logic [NB_WRAGENT-1:0] bank_en;
  logic [RD_W-1:0]       bank_sel [NB_WRAGENT];
  logic [RD_W-1:0]       ptr      [NB_WRAGENT];
  logic [DATA_WIDTH-1:0] bank_q   [NB_WRAGENT];

  logic [NB_RDAGENT-1:0] dvalid_q;
  logic [NB_RDAGENT-1:0] err_q;
  logic [BANK_W-1:0]     src_q    [NB_RDAGENT];
  logic [DATA_WIDTH-1:0] hold_q   [NB_RDAGENT];
  logic [DATA_WIDTH-1:0] dout     [NB_RDAGENT];

  // Unpack per-reader fields and flag bank indices beyond the last bank.
  // When the bank count is a power of two every index is a real bank.
  for (genvar r = 0; r < NB_RDAGENT; r++) begin : g_rd
    assign rbank[r] = rd_bank[r*BANK_W +: BANK_W];
    assign raddr[r] = rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_data[r*DATA_WIDTH +: DATA_WIDTH] = dout[r];
    if (BANK_FULL) begin : g_noob
      assign oob[r] = 1'b0;
    end else begin : g_oob
      assign oob[r] = (int'(rbank[r]) >= NB_WRAGENT);
    end
  end

  // Per-bank round-robin search. The search starts at the bank's pointer and
  // wraps around, and the first requester it finds wins. Out-of-range
  // requests never match a real bank index, so they never consume a grant.
  always_comb begin
    int idx;
    logic [RD_W-1:0] sel;
    gnt     = '0;
    bank_en = '0;
    idx     = 0;
    sel     = '0;
    for (int b = 0; b < NB_WRAGENT; b++) begin
      bank_sel[b] = '0;
      for (int k = 0; k < NB_RDAGENT; k++) begin
        idx = int'(ptr[b]) + k;
        if (idx >= NB_RDAGENT) idx = idx - NB_RDAGENT;
        sel = RD_W'(idx);
        if (!bank_en[b] && rd_valid[sel] && (int'(rbank[sel]) == b)) begin
          bank_en[b]  = 1'b1;
          bank_sel[b] = sel;
          gnt[sel]    = 1'b1;
        end
      end
    end
  end

  // Out-of-range requests are accepted at once. They are answered with an error.
  assign rd_ready = gnt | (rd_valid & oob);

  // After a grant, the pointer moves to the reader just past the winner.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int b = 0; b < NB_WRAGENT; b++) ptr[b] <= '0;
    end else begin
      for (int b = 0; b < NB_WRAGENT; b++) begin
        if (bank_en[b]) begin
          ptr[b] <= (bank_sel[b] == RD_W'(NB_RDAGENT - 1)) ? '0 : bank_sel[b] + 1'b1;
        end
      end
    end
  end

  // One RAM per bank. It has a synchronous read register and no reset, so
  // it can infer a block RAM. An address past RAM_DEPTH reads as zero and
  // a write to such an address is dropped.
  for (genvar gb = 0; gb < NB_WRAGENT; gb++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] q;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] baddr;
    logic                  wr_ok;
    logic                  rd_ok;

    assign waddr      = wraddr[gb*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata      = wrdata[gb*DATA_WIDTH +: DATA_WIDTH];
    assign baddr      = raddr[bank_sel[gb]];
    assign bank_q[gb] = q;

    if (ADDR_FULL) begin : g_full
      assign wr_ok = 1'b1;
      assign rd_ok = 1'b1;
    end else begin : g_part
      assign wr_ok = (int'(waddr) < RAM_DEPTH);
      assign rd_ok = (int'(baddr) < RAM_DEPTH);
    end

    always_ff @(posedge aclk) begin
      if (wren[gb] && wr_ok) mem[waddr] <= wdata;
      if (bank_en[gb]) begin
        if (!rd_ok) q <= '0;
`ifdef MEDURAM_WR_BYPASS_EN
        else if (wren[gb] && (waddr == baddr)) q <= wdata;
`endif
        else q <= mem[baddr];
      end
    end
  end

  // Per-reader response tracking. hold_q captures what the reader sees on
  // every cycle, so the data stays put between pulses. Reset clears it,
  // which makes rd_data read zero after reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dvalid_q <= '0;
      err_q    <= '0;
      for (int r = 0; r < NB_RDAGENT; r++) begin
        src_q[r]  <= '0;
        hold_q[r] <= '0;
      end
    end else begin
      dvalid_q <= rd_valid & rd_ready;
      err_q    <= rd_valid & oob;
      for (int r = 0; r < NB_RDAGENT; r++) begin
        hold_q[r] <= dout[r];
        if (rd_valid[r] && rd_ready[r]) src_q[r] <= rbank[r];
      end
    end
  end

  // Route the bank that served each reader onto that reader's data lane
  // during the response cycle.
  always_comb begin
    for (int r = 0; r < NB_RDAGENT; r++) begin
      dout[r] = hold_q[r];
      if (dvalid_q[r]) begin
        if (err_q[r]) begin
          dout[r] = '0;
        end else begin
          for (int b = 0; b < NB_WRAGENT; b++) begin
            if (src_q[r] == BANK_W'(b)) dout[r] = bank_q[b];
          end
        end
      end
    end
  end

  assign rd_dvalid = dvalid_q;
  assign rd_err    = err_q;

endmodule

// File: tb/tb_bram_bank_xbar.sv
// tb_bram_bank_xbar
//   Self-checking bench for bram_bank_xbar. The instance has 3 banks and
//   2 readers, so a rd_bank value of 3 is out of range. A behavioural model
//   holds the RAM contents and the round-robin pointers as plain arrays.
//   It derives the expected ready, response and data values for every
//   cycle. Honours MEDURAM_WR_BYPASS_EN in the same way as the design.
module tb_bram_bank_xbar;

  localparam int NBW   = 3;
  localparam int NBR   = 2;
  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int BW    = 2;
  localparam int DEPTH = 8;

  logic              aclk;
  logic              aresetn;
  logic [NBW-1:0]    wren;
  logic [AW*NBW-1:0] wraddr;
  logic [DW*NBW-1:0] wrdata;
  logic [NBR-1:0]    rd_valid;
  logic [NBR-1:0]    rd_ready;
  logic [BW*NBR-1:0] rd_bank;
  logic [AW*NBR-1:0] rd_addr;
  logic [NBR-1:0]    rd_dvalid;
  logic [DW*NBR-1:0] rd_data;
  logic [NBR-1:0]    rd_err;

  int vectors;
  int miscompares;

  // Reference model state
  logic [DW-1:0]     mem_m [NBW][DEPTH];
  int                ptr_m [NBW];
  int                nx_ptr [NBW];
  logic [NBR-1:0]    exp_ready, exp_dvalid, exp_err, nx_dvalid, nx_err;
  logic [DW*NBR-1:0] exp_data, nx_data;

  bram_bank_xbar #(
    .NB_WRAGENT(NBW), .NB_RDAGENT(NBR), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .DATA_WIDTH(DW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_dvalid(rd_dvalid), .rd_data(rd_data), .rd_err(rd_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Model: results of the current cycle's inputs
  task automatic model_eval();
    bit taken;
    int g;
    int ad;
    exp_ready = '0;
    nx_dvalid = '0;
    nx_err    = '0;
    nx_data   = exp_data;
    for (int b = 0; b < NBW; b++) nx_ptr[b] = ptr_m[b];
    for (int r = 0; r < NBR; r++) begin
      if (rd_valid[r] && int'(rd_bank[r*BW +: BW]) >= NBW) begin
        exp_ready[r] = 1'b1;
        nx_dvalid[r] = 1'b1;
        nx_err[r]    = 1'b1;
        nx_data[r*DW +: DW] = 8'h00;
      end
    end
    for (int b = 0; b < NBW; b++) begin
      taken = 1'b0;
      for (int k = 0; k < NBR; k++) begin
        g = (ptr_m[b] + k) % NBR;
        if (!taken && rd_valid[g] && int'(rd_bank[g*BW +: BW]) == b) begin
          taken        = 1'b1;
          exp_ready[g] = 1'b1;
          nx_dvalid[g] = 1'b1;
          nx_ptr[b]    = (g + 1) % NBR;
          ad = int'(rd_addr[g*AW +: AW]);
          nx_data[g*DW +: DW] = (ad < DEPTH) ? mem_m[b][ad] : 8'h00;
`ifdef MEDURAM_WR_BYPASS_EN
          if (wren[b] && int'(wraddr[b*AW +: AW]) == ad) nx_data[g*DW +: DW] = wrdata[b*DW +: DW];
`endif
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NBW; b++) ptr_m[b] = 0;
    exp_dvalid = '0;
    exp_err    = '0;
    exp_data   = '0;
  endtask

  task automatic model_commit();
    if (!aresetn) begin
      model_reset();
    end else begin
      for (int b = 0; b < NBW; b++) begin
        if (wren[b] && int'(wraddr[b*AW +: AW]) < DEPTH)
          mem_m[b][int'(wraddr[b*AW +: AW])] = wrdata[b*DW +: DW];
        ptr_m[b] = nx_ptr[b];
      end
      exp_dvalid = nx_dvalid;
      exp_err    = nx_err;
      exp_data   = nx_data;
    end
  endtask

  // Timing helpers: sample on the falling edge, drive 1ns after the rising edge
  task automatic to_neg();
    @(negedge aclk);
    model_eval();
  endtask

  task automatic to_next();
    @(posedge aclk);
    model_commit();
    #1;
  endtask

  task automatic drive_idle();
    wren = '0; wraddr = '0; wrdata = '0;
    rd_valid = '0; rd_bank = '0; rd_addr = '0;
  endtask

  task automatic set_read(input int r, input int bank, input int addr);
    rd_valid[r] = 1'b1;
    rd_bank[r*BW +: BW] = BW'(bank);
    rd_addr[r*AW +: AW] = AW'(addr);
  endtask

  task automatic set_write(input int b, input int addr, input logic [DW-1:0] d);
    wren[b] = 1'b1;
    wraddr[b*AW +: AW] = AW'(addr);
    wrdata[b*DW +: DW] = d;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    drive_idle();
    model_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 3) aresetn = 1'b1;
      to_neg();
      vectors++;
      if ({rd_dvalid, rd_data, rd_err} !== {2'b00, 16'h0000, 2'b00}) begin
        miscompares++;
        $display("[TB] FAIL reset c=%0d: got dv=%b data=%h err=%b want 0", c, rd_dvalid, rd_data, rd_err);
      end
      to_next();
    end
  endtask

  task automatic test_prefill();
    for (int a = 0; a < DEPTH; a++) begin
      drive_idle();
      for (int b = 0; b < NBW; b++) set_write(b, a, DW'($urandom));
      to_neg();
      to_next();
    end
    drive_idle();
  endtask

  task automatic test_single_read();
    drive_idle();
    set_write(1, 5, 8'hA5);
    to_neg();
    to_next();
    drive_idle();
    set_read(0, 1, 5);
    to_neg();
    vectors++;
    if (rd_ready[0] !== 1'b1) begin
      miscompares++; $display("[TB] FAIL single_ready: got %b want 1", rd_ready[0]);
    end
    to_next();
    drive_idle();
    to_neg();
    vectors++;
    if ({rd_dvalid[0], rd_data[7:0], rd_err[0]} !== {1'b1, 8'hA5, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL single_resp: got dv=%b data=%h err=%b want 1 a5 0", rd_dvalid[0], rd_data[7:0], rd_err[0]);
    end
    to_next();
  endtask

  task automatic test_round_robin();
    logic [1:0] pat [4];
    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b10;
    drive_idle();
    set_read(0, 0, 1);
    set_read(1, 0, 3);
    for (int c = 0; c < 5; c++) begin
      if (c == 4) drive_idle();
      to_neg();
      vectors++;
      if ({rd_ready, rd_dvalid, rd_err} !== {exp_ready, exp_dvalid, exp_err}) begin
        miscompares++;
        $display("[TB] FAIL rr_hs c=%0d: got %b want %b", c, {rd_ready, rd_dvalid, rd_err}, {exp_ready, exp_dvalid, exp_err});
      end
      vectors++;
      if (rd_data !== exp_data) begin
        miscompares++; $display("[TB] FAIL rr_data c=%0d: got %h want %h", c, rd_data, exp_data);
      end
      if (c < 4) begin
        vectors++;
        if (rd_ready !== pat[c]) begin
          miscompares++; $display("[TB] FAIL rr_order c=%0d: got %b want %b", c, rd_ready, pat[c]);
        end
      end
      to_next();
    end
  endtask

  task automatic test_parallel_banks();
    drive_idle();
    set_read(0, 0, 4);
    set_read(1, 1, 6);
    to_neg();
    vectors++;
    if (rd_ready !== 2'b11) begin
      miscompares++; $display("[TB] FAIL par_ready: got %b want 11", rd_ready);
    end
    to_next();
    drive_idle();
    to_neg();
    vectors++;
    if ({rd_dvalid, rd_data} !== {2'b11, exp_data}) begin
      miscompares++; $display("[TB] FAIL par_resp: got %b %h want 11 %h", rd_dvalid, rd_data, exp_data);
    end
    to_next();
    to_neg();
    vectors++;
    if (rd_dvalid !== 2'b00) begin
      miscompares++; $display("[TB] FAIL par_pulse: got %b want 00", rd_dvalid);
    end
    to_next();
  endtask

  task automatic test_bypass_oob();
    logic [7:0] want;
`ifdef MEDURAM_WR_BYPASS_EN
    want = 8'h22;
`else
    want = 8'h11;
`endif
    drive_idle();
    set_write(0, 2, 8'h11);
    to_neg();
    to_next();
    drive_idle();
    set_write(0, 2, 8'h22);
    set_read(0, 0, 2);
    set_read(1, 3, 0);
    to_neg();
    vectors++;
    if (rd_ready !== 2'b11) begin
      miscompares++; $display("[TB] FAIL byp_ready: got %b want 11", rd_ready);
    end
    to_next();
    drive_idle();
    to_neg();
    vectors++;
    if ({rd_dvalid, rd_err, rd_data} !== {2'b11, 2'b10, 8'h00, want}) begin
      miscompares++;
      $display("[TB] FAIL byp_oob: got dv=%b err=%b data=%h want 11 10 00%h", rd_dvalid, rd_err, rd_data, want);
    end
    to_next();
  endtask

  task automatic test_reset_midop();
    drive_idle();
    set_read(0, 2, 1);
    to_neg();
    to_next();
    aresetn = 1'b0;
    drive_idle();
    model_reset();
    #1;
    vectors++;
    if ({rd_dvalid, rd_err, rd_data} !== 20'h0) begin
      miscompares++; $display("[TB] FAIL midreset: got dv=%b err=%b data=%h want 0", rd_dvalid, rd_err, rd_data);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    set_read(1, 2, 3);
    set_read(0, 2, 5);
    to_neg();
    vectors++;
    if (rd_ready !== 2'b01) begin
      miscompares++; $display("[TB] FAIL midreset_ptr: got %b want 01", rd_ready);
    end
    to_next();
    drive_idle();
    to_neg();
    vectors++;
    if ({rd_dvalid, rd_data} !== {exp_dvalid, exp_data}) begin
      miscompares++; $display("[TB] FAIL midreset_resp: got %b %h want %b %h", rd_dvalid, rd_data, exp_dvalid, exp_data);
    end
    to_next();
  endtask

  task automatic test_random();
    logic [NBR-1:0] accepted;
    accepted = '0;
    drive_idle();
    for (int c = 0; c < 400; c++) begin
      wren   = NBW'($urandom_range(0, 7));
      wraddr = (AW*NBW)'($urandom);
      wrdata = (DW*NBW)'($urandom);
      for (int r = 0; r < NBR; r++) begin
        if (!rd_valid[r] || accepted[r]) begin
          rd_valid[r] = ($urandom_range(0, 3) != 0);
          rd_bank[r*BW +: BW] = BW'($urandom_range(0, 3));
          rd_addr[r*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
        end
      end
      to_neg();
      accepted = exp_ready;
      vectors++;
      if ({rd_ready, rd_dvalid, rd_err} !== {exp_ready, exp_dvalid, exp_err}) begin
        miscompares++;
        $display("[TB] FAIL rnd_hs c=%0d: got %b want %b", c, {rd_ready, rd_dvalid, rd_err}, {exp_ready, exp_dvalid, exp_err});
      end
      vectors++;
      if (rd_data !== exp_data) begin
        miscompares++; $display("[TB] FAIL rnd_data c=%0d: got %h want %h", c, rd_data, exp_data);
      end
      to_next();
    end
    drive_idle();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_prefill();
    test_single_read();
    test_round_robin();
    test_parallel_banks();
    test_bypass_oob();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
